// File: rtl/cic_comb_decim.sv
// Comb/decimator half of a CIC decimation filter: decimates by 2^os_sel, runs
// N_STAGE differentiators at the decimated rate, removes the R^N gain and saturates.
module cic_comb_decim #(
   parameter int IDW     = 23,
   parameter int ODW     = 16,
   parameter int N_STAGE = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           enable,
   input  logic [2:0]     os_sel,
   input  logic [IDW-1:0] data_in,
   output logic [ODW-1:0] data_out,
   output logic           data_vld,
   output logic [1:0]     sat_flag,
   output logic           os_err
);

   localparam logic [2:0] WARM_INIT = 3'(N_STAGE);
   localparam logic signed [IDW:0] SAT_MAX = {{(IDW-ODW+2){1'b0}}, {(ODW-1){1'b1}}};
   localparam logic signed [IDW:0] SAT_MIN = {{(IDW-ODW+2){1'b1}}, {(ODW-1){1'b0}}};

   logic [2:0]     r_os_sel_q;
   logic [5:0]     r_dec_cnt;
   logic [IDW-1:0] r_z [N_STAGE];
   logic [2:0]     r_warm;

   logic                  w_change;
   logic                  w_invalid;
   logic [6:0]            w_r;
   logic [5:0]            w_last;
   logic                  w_tick;
   logic [IDW-1:0]        w_x [N_STAGE];
   logic [IDW-1:0]        w_y;
   logic [4:0]            w_s;
   logic signed [IDW:0]   w_ext;
   logic signed [IDW:0]   w_round;
   logic signed [IDW:0]   w_v;
   logic                  w_pos_clamp;
   logic                  w_neg_clamp;
   logic [ODW-1:0]        w_sat_val;

   // A change of os_sel restarts the filter and always wins over a tick.
   assign w_change  = (os_sel != r_os_sel_q);
   assign w_invalid = (os_sel == 3'b111);
   assign w_r       = 7'd1 << os_sel;
   assign w_last    = (os_sel == 3'd0 || w_invalid) ? 6'd0 : 6'(w_r - 7'd1);
   assign w_tick    = enable && !w_change && (r_dec_cnt == w_last);

   always_comb begin
      logic [IDW-1:0] v_acc;
      v_acc = data_in;
      for (int k = 0; k < N_STAGE; k++) begin
         w_x[k] = v_acc;
         v_acc  = v_acc - r_z[k];
      end
      w_y = v_acc;
   end

   // Gain removal: round half up, then arithmetic shift in IDW+1 bits.
   assign w_s         = (os_sel == 3'd0 || w_invalid) ? 5'd0 : 5'(int'(os_sel) * N_STAGE);
   assign w_ext       = {w_y[IDW-1], w_y};
   assign w_round     = (w_s == 5'd0) ? '0 : ({{IDW{1'b0}}, 1'b1} << (w_s - 5'd1));
   assign w_v         = (w_ext + w_round) >>> w_s;
   assign w_pos_clamp = (w_v > SAT_MAX);
   assign w_neg_clamp = (w_v < SAT_MIN);
   assign w_sat_val   = w_pos_clamp ? {1'b0, {(ODW-1){1'b1}}} :
                        w_neg_clamp ? {1'b1, {(ODW-1){1'b0}}} : w_v[ODW-1:0];

   // data_vld is a single-cycle strobe with no back-pressure: data_out is new
   // in the cycle data_vld is high and holds until the next strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_os_sel_q <= 3'd0;
         r_dec_cnt  <= 6'd0;
         r_warm     <= WARM_INIT;
         for (int k = 0; k < N_STAGE; k++) r_z[k] <= '0;
         data_out   <= '0;
         data_vld   <= 1'b0;
         sat_flag   <= 2'b00;
         os_err     <= 1'b0;
      end else begin
         r_os_sel_q <= os_sel;
         os_err     <= w_invalid;
         data_vld   <= 1'b0;
         if (w_change) begin
            r_dec_cnt <= 6'd0;
            r_warm    <= WARM_INIT;
            for (int k = 0; k < N_STAGE; k++) r_z[k] <= '0;
         end else if (enable) begin
            if (w_tick) begin
               r_dec_cnt <= 6'd0;
               for (int k = 0; k < N_STAGE; k++) r_z[k] <= w_x[k];
               data_out <= w_sat_val;
               if (w_pos_clamp || w_neg_clamp) sat_flag <= {w_neg_clamp, ~sat_flag[0]};
               if (r_warm != 3'd0) r_warm <= r_warm - 3'd1;
               else                data_vld <= 1'b1;
            end else begin
               r_dec_cnt <= r_dec_cnt + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cic_comb_decim.sv
// Bench for cic_comb_decim: vector table, hand-written corner sequences and a
// randomized run checked against an N-th-difference reference model.
module tb_cic_comb_decim;

   localparam int IDW     = 23;
   localparam int ODW     = 16;
   localparam int N_STAGE = 1;
   localparam longint MAXV = (longint'(1) << (ODW-1)) - 1;
   localparam longint MINV = -(longint'(1) << (ODW-1));

   logic           clk = 1'b0;
   logic           reset_n;
   logic           enable;
   logic [2:0]     os_sel;
   logic [IDW-1:0] data_in;
   logic [ODW-1:0] data_out;
   logic           data_vld;
   logic [1:0]     sat_flag;
   logic           os_err;

   cic_comb_decim #(.IDW(IDW), .ODW(ODW), .N_STAGE(N_STAGE)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .os_sel(os_sel),
      .data_in(data_in), .data_out(data_out), .data_vld(data_vld),
      .sat_flag(sat_flag), .os_err(os_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic           en;
      logic [2:0]     os;
      logic [IDW-1:0] din;
      logic [ODW-1:0] exp_out;
      logic           exp_vld;
      logic [1:0]     exp_sat;
      logic           exp_err;
   } vec_t;
   vec_t tbl [12];

   // Reference model: samples kept since the last restart, output is the
   // N-th backward difference of the decimated sequence (zeros before restart).
   int             m_prev_os;
   int             m_en_cnt;
   int             m_ticks;
   longint         m_hist [$];
   logic [ODW-1:0] m_out;
   logic           m_vld;
   logic [1:0]     m_sat;
   logic           m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev_os = 0; m_en_cnt = 0; m_ticks = 0; m_hist.delete();
      m_out = '0; m_vld = 1'b0; m_sat = 2'b00; m_err = 1'b0;
   endtask

   function automatic longint binom(input int n, input int k);
      longint c = 1;
      for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
      return c;
   endfunction

   function automatic longint wrap_idw(input longint y);
      longint r = y & ((longint'(1) << IDW) - 1);
      if (r >= (longint'(1) << (IDW-1))) r = r - (longint'(1) << IDW);
      return r;
   endfunction

   task automatic model_step(input logic en, input logic [2:0] os, input logic [IDW-1:0] din);
      int rate, s;
      longint y, v;
      m_vld = 1'b0;
      if (int'(os) != m_prev_os) begin
         m_en_cnt = 0; m_ticks = 0; m_hist.delete();
      end else if (en) begin
         rate = (os == 0 || os == 7) ? 1 : (1 << os);
         m_en_cnt++;
         if (m_en_cnt % rate == 0) begin
            m_hist.push_front(longint'(din));
            if (m_hist.size() > N_STAGE + 1) void'(m_hist.pop_back());
            y = 0;
            for (int k = 0; k <= N_STAGE; k++)
               if (k < m_hist.size())
                  y = y + ((k % 2 == 1) ? -1 : 1) * binom(N_STAGE, k) * m_hist[k];
            y = wrap_idw(y);
            s = (os == 0 || os == 7) ? 0 : int'(os) * N_STAGE;
            v = (s > 0) ? ((y + (longint'(1) << (s-1))) >>> s) : y;
            if (v > MAXV) begin
               m_out = ODW'(MAXV); m_sat = {1'b0, ~m_sat[0]};
            end else if (v < MINV) begin
               m_out = ODW'(MINV); m_sat = {1'b1, ~m_sat[0]};
            end else begin
               m_out = ODW'(v);
            end
            m_ticks++;
            m_vld = (m_ticks > N_STAGE);
         end
      end
      m_prev_os = int'(os);
      m_err = (os == 3'b111);
   endtask

   task automatic cycle(input logic en, input logic [2:0] os, input logic [IDW-1:0] din);
      enable = en; os_sel = os; data_in = din;
      model_step(en, os, din);
      @(posedge clk); #1;
      chk("model_out", 32'(data_out), 32'(m_out));
      chk("model_vld", 32'(data_vld), 32'(m_vld));
      chk("model_sat", 32'(sat_flag), 32'(m_sat));
      chk("model_err", 32'(os_err), 32'(m_err));
   endtask

   task automatic do_reset(input logic [2:0] os);
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enable = 1'($urandom_range(0, 1)); os_sel = 3'($urandom_range(0, 7));
         data_in = IDW'($urandom);
         @(posedge clk); #1;
         chk("rst_out", 32'(data_out), 32'd0);
         chk("rst_vld", 32'(data_vld), 32'd0);
         chk("rst_sat", 32'(sat_flag), 32'd0);
         chk("rst_err", 32'(os_err), 32'd0);
      end
      os_sel = os; enable = 1'b0; data_in = '0;
      model_reset();
      @(negedge clk); reset_n = 1'b1;
   endtask

   initial begin
      logic [IDW-1:0] acc;
      int last, nstrobe, first;
      tbl[0]  = '{1'b1, 3'd0, 23'd100,      16'd100,  1'b0, 2'b00, 1'b0};
      tbl[1]  = '{1'b1, 3'd0, 23'd150,      16'd50,   1'b1, 2'b00, 1'b0};
      tbl[2]  = '{1'b0, 3'd0, 23'd999,      16'd50,   1'b0, 2'b00, 1'b0};
      tbl[3]  = '{1'b1, 3'd0, 23'd100,      16'hFFCE, 1'b1, 2'b00, 1'b0};
      tbl[4]  = '{1'b1, 3'd0, 23'h3FFFF0,   16'h7FFF, 1'b1, 2'b01, 1'b0};
      tbl[5]  = '{1'b1, 3'd0, 23'h400010,   16'h0020, 1'b1, 2'b01, 1'b0};
      tbl[6]  = '{1'b1, 3'd7, 23'h400020,   16'h0020, 1'b0, 2'b01, 1'b1};
      tbl[7]  = '{1'b1, 3'd7, 23'd500,      16'd500,  1'b0, 2'b01, 1'b1};
      tbl[8]  = '{1'b1, 3'd7, 23'd400,      16'hFF9C, 1'b1, 2'b01, 1'b1};
      tbl[9]  = '{1'b1, 3'd0, 23'd400,      16'hFF9C, 1'b0, 2'b01, 1'b0};
      tbl[10] = '{1'b1, 3'd0, 23'd400,      16'd400,  1'b0, 2'b01, 1'b0};
      tbl[11] = '{1'b1, 3'd0, 23'h7E0190,   16'h8000, 1'b1, 2'b10, 1'b0};

      reset_n = 1'b0; enable = 1'b0; os_sel = 3'd0; data_in = '0;
      do_reset(3'd0);

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].en, tbl[i].os, tbl[i].din);
         chk($sformatf("tbl%0d_out", i), 32'(data_out), 32'(tbl[i].exp_out));
         chk($sformatf("tbl%0d_vld", i), 32'(data_vld), 32'(tbl[i].exp_vld));
         chk($sformatf("tbl%0d_sat", i), 32'(sat_flag), 32'(tbl[i].exp_sat));
         chk($sformatf("tbl%0d_err", i), 32'(os_err),   32'(tbl[i].exp_err));
      end

      // DC input through an integrator, os_sel=2.
      do_reset(3'd2);
      acc = '0; last = -1; nstrobe = 0;
      for (int i = 0; i < 80; i++) begin
         acc = acc + IDW'(1000);
         cycle(1'b1, 3'd2, acc);
         if (data_vld) begin
            nstrobe++;
            chk("dc2_val", 32'(data_out), 32'd1000);
            if (last >= 0) chk("dc2_period", 32'(i - last), 32'd4);
            last = i;
         end
      end
      chk("dc2_count", 32'(nstrobe), 32'd18);

      // Switch to os_sel=5 mid-stream.
      last = -1; nstrobe = 0; first = -1;
      for (int i = 0; i < 200; i++) begin
         acc = acc + IDW'(1000);
         cycle(1'b1, 3'd5, acc);
         if (data_vld) begin
            nstrobe++;
            if (first < 0) first = i;
            chk("dc5_val", 32'(data_out), 32'd1000);
            if (last >= 0) chk("dc5_period", 32'(i - last), 32'd32);
            last = i;
         end
      end
      chk("dc5_first", 32'(first), 32'd64);
      chk("dc5_count", 32'(nstrobe), 32'd5);

      // Invalid os_sel, then enable held low.
      cycle(1'b1, 3'd7, acc);
      chk("os7_err", 32'(os_err), 32'd1);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 3'd7, IDW'($urandom));
         chk("os7_hold_vld", 32'(data_vld), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         acc = acc + IDW'(1000);
         cycle(1'b1, 3'd7, acc);
         if (i > 0) chk("os7_vld", 32'(data_vld), 32'd1);
      end

      // Randomized run with a mid-stream asynchronous reset.
      os_sel = 3'd3;
      for (int i = 0; i < 1500; i++) begin
         logic [2:0] os;
         os = os_sel;
         if ($urandom_range(0, 59) == 0) os = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) acc = IDW'($urandom);
         else acc = acc + IDW'($urandom_range(0, 8191));
         cycle(1'($urandom_range(0, 3) != 0), os, acc);
         if (i == 700) begin
            reset_n = 1'b0; #2;
            chk("arst_out", 32'(data_out), 32'd0);
            chk("arst_vld", 32'(data_vld), 32'd0);
            chk("arst_sat", 32'(sat_flag), 32'd0);
            chk("arst_err", 32'(os_err), 32'd0);
            model_reset();
            @(negedge clk); reset_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
